// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// The fetch unit drives the word and PC; decode returns out_ready.
interface instruction_fetch_unit_if #(
   parameter int PC_WIDTH    = 6,
   parameter int INSTR_WIDTH = 32
);
   logic [INSTR_WIDTH-1:0] out_instr;
   logic [PC_WIDTH-1:0]    out_pc;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      output out_instr,
      output out_pc,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_instr,
      input  out_pc,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator for a one-cycle synchronous instruction memory.
// Streams PC-tagged words to decode with stall, redirect and enable.
module instruction_fetch_unit #(
   parameter int                PC_WIDTH    = 6,
   parameter int                INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                CNT_WIDTH   = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   fetch_en,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    PC,
   input  logic [INSTR_WIDTH-1:0] Instruction,
   instruction_fetch_unit_if.master dec,
   output logic                   misalign_err,
   output logic [CNT_WIDTH-1:0]   accept_count
);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] resp_pc_q;
   logic                stall;
   logic                accept;

   assign dec.out_valid = (state_q == STREAM);
   assign dec.out_pc    = resp_pc_q;
   assign dec.out_instr = Instruction;

   assign stall  = dec.out_valid && !dec.out_ready;
   assign accept = dec.out_valid && dec.out_ready;

   // Re-issuing the stalled address keeps Instruction stable.
   assign PC = stall ? resp_pc_q : pc_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         misalign_err <= 1'b0;
         accept_count <= '0;
      end else begin
         misalign_err <= 1'b0;
         if (accept)
            accept_count <= accept_count + CNT_WIDTH'(1);
         if (branch_taken) begin
            pc_q         <= {branch_target[PC_WIDTH-1:2], 2'b00};
            state_q      <= IDLE;
            misalign_err <= (branch_target[1:0] != 2'b00);
         end else if (!stall) begin
            if (fetch_en) begin
               resp_pc_q <= pc_q;
               pc_q      <= pc_q + PC_WIDTH'(4);
               state_q   <= STREAM;
            end else begin
               state_q   <= IDLE;
            end
         end
      end
   end

endmodule
